// File: rtl/bcd_serial_adder_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_adder_seq_if
// Description : Operand/result handshakes plus the digit-adder side channel
//               of the digit-serial BCD adder sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_serial_adder_seq_if #(
    parameter int NDIGITS = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4*NDIGITS-1:0]   in_a;
    logic [4*NDIGITS-1:0]   in_b;
    logic                   in_cin;
    logic [3:0]             dig_a;
    logic [3:0]             dig_b;
    logic                   dig_cin;
    logic [3:0]             dig_sum;
    logic                   dig_cout;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*NDIGITS-1:0]   out_sum;
    logic                   out_cout;
    logic                   out_err;

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, in_cin, dig_sum, dig_cout, out_ready,
        output in_ready, dig_a, dig_b, dig_cin, out_valid, out_sum, out_cout, out_err
    );

    // Environment side: operand source, result sink and digit adder
    modport master (
        output in_valid, in_a, in_b, in_cin, dig_sum, dig_cout, out_ready,
        input  in_ready, dig_a, dig_b, dig_cin, out_valid, out_sum, out_cout, out_err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_adder_seq
// Description : Adds two NDIGITS-wide packed-BCD operands one digit per clock
//               using an external combinational single-digit BCD adder.
//               Optional invalid-digit flag enabled by BCD_SEQ_DIGIT_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_adder_seq #(
    parameter int NDIGITS = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    bcd_serial_adder_seq_if.slave   bus
);
    localparam int                  c_idx_w    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(NDIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [4*NDIGITS-1:0]   r_a;
    logic [4*NDIGITS-1:0]   r_b;
    logic [4*NDIGITS-1:0]   r_sum;
    logic                   r_carry;
    logic                   r_cout;
    logic [c_idx_w-1:0]     r_idx;
    logic                   w_accept;
    logic                   w_run;
    logic                   w_last;
    logic [3:0]             w_dig_a;
    logic [3:0]             w_dig_b;

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_run    = (r_state == S_RUN);
    assign w_last   = (r_idx == c_last_idx);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)        w_state_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    // Select the current operand digits from the latched operands; zero outside RUN
    always_comb begin
        w_dig_a = 4'd0;
        w_dig_b = 4'd0;
        if (w_run) begin
            for (int d = 0; d < NDIGITS; d++) begin
                if (r_idx == c_idx_w'(d)) begin
                    w_dig_a = r_a[4*d +: 4];
                    w_dig_b = r_b[4*d +: 4];
                end
            end
        end
    end

    assign bus.dig_a     = w_dig_a;
    assign bus.dig_b     = w_dig_b;
    assign bus.dig_cin   = w_run & r_carry;
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;

    // Operand latch, digit walk, carry chain and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_carry <= bus.in_cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_run) begin
            for (int d = 0; d < NDIGITS; d++) begin
                if (r_idx == c_idx_w'(d)) r_sum[4*d +: 4] <= bus.dig_sum;
            end
            r_carry <= bus.dig_cout;
            if (w_last) begin
                r_cout <= bus.dig_cout;
                r_idx  <= '0;
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

`ifdef BCD_SEQ_DIGIT_CHECK_EN
    logic r_err;
    logic w_bad_digit;

    assign w_bad_digit = (w_dig_a > 4'd9) || (w_dig_b > 4'd9);

    // Sticky invalid-digit flag, cleared when a new operation is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_err <= 1'b0;
        else if (w_accept)               r_err <= 1'b0;
        else if (w_run && w_bad_digit)   r_err <= 1'b1;
    end

    assign bus.out_err = r_err;
`else
    assign bus.out_err = 1'b0;
`endif

endmodule
`default_nettype wire
